// File: rtl/pwm_generator.sv
// pwm_generator
//   Turns an 8-bit duty ratio and a direction bit into a registered PWM
//   waveform and direction pin for the steering motor driver. New settings
//   wait in a pending buffer and are applied only on a period boundary.
//   A direction reversal first forces the output low for DEAD_PERIODS whole
//   periods.
//
// Upstream handshake: pwm_update is a write strobe with no back-pressure.
//   Every cycle it is high, pwm_ratio/pwm_direction overwrite the pending
//   buffer, so the last write before a boundary wins. pwm_done is a one-clock
//   acknowledge that the most recently loaded setting has completed one full
//   period.
//
// Ports:
//   clock          main clock
//   reset_n        asynchronous active-low reset
//   pwm_enable     level; 0 forces the output low and holds the counters
//   pwm_update     pending-buffer write strobe
//   pwm_ratio      requested high time out of 255
//   pwm_direction  requested motor direction
//   pwm_done       one-clock acknowledge, see above
//   pwm_signal     registered PWM waveform
//   dir_signal     registered applied direction
//   dbg_state_o    current FSM state (0 DISABLED, 1 RUN, 2 DEAD)
module pwm_generator #(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pwm_enable,
    input  logic       pwm_update,
    input  logic [7:0] pwm_ratio,
    input  logic       pwm_direction,
    output logic       pwm_done,
    output logic       pwm_signal,
    output logic       dir_signal,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_DEAD     = 2'd2
    } state_e;

    localparam logic [7:0] PRE_LAST  = 8'(PRESCALE - 1);
    localparam logic [7:0] CNT_LAST  = 8'd254;
    localparam logic [3:0] DEAD_INIT = 4'(DEAD_PERIODS - 1);

    state_e     state_q, state_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] active_q, active_d;
    logic [7:0] pend_ratio_q, pend_ratio_d;
    logic       pend_dir_q, pend_dir_d;
    logic       pend_valid_q, pend_valid_d;
    logic       armed_q, armed_d;
    logic [3:0] dead_q, dead_d;
    logic       dir_q, dir_d;
    logic       pwm_q, pwm_d;
    logic       done_q, done_d;

    logic tick;
    logic period_end;
    logic consume;

    assign tick       = (pre_q == PRE_LAST);
    assign period_end = tick && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        armed_d  = armed_q;
        dead_d   = dead_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        consume  = 1'b0;
        // Gating with pwm_enable makes the output drop on the very edge that
        // sees the enable fall.
        pwm_d    = pwm_enable && (cnt_q < active_q);

        if (!pwm_enable) begin
            state_d  = ST_DISABLED;
            pre_d    = 8'd0;
            cnt_d    = 8'd0;
            active_d = 8'd0;
            armed_d  = 1'b0;
        end else begin
            if (state_q != ST_DISABLED) begin
                pre_d = tick ? 8'd0 : pre_q + 8'd1;
                if (tick) begin
                    cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
                end
            end

            case (state_q)
                ST_DISABLED: begin
                    // Counters are already 0, so the next clock starts a period.
                    // active is 0 here, so a pending setting loads directly.
                    state_d = ST_RUN;
                    if (pend_valid_q) begin
                        active_d = pend_ratio_q;
                        dir_d    = pend_dir_q;
                        armed_d  = 1'b1;
                        consume  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (period_end) begin
                        if (armed_q) begin
                            done_d  = 1'b1;
                            armed_d = 1'b0;
                        end
                        if (pend_valid_q) begin
                            if ((pend_dir_q == dir_q) || (active_q == 8'd0)) begin
                                active_d = pend_ratio_q;
                                dir_d    = pend_dir_q;
                                armed_d  = 1'b1;
                                consume  = 1'b1;
                            end else begin
                                // Reversal under load: go low first, keep the
                                // request pending until the off-time expires.
                                active_d = 8'd0;
                                dead_d   = DEAD_INIT;
                                state_d  = ST_DEAD;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (period_end) begin
                        if (dead_q != 4'd0) begin
                            dead_d = dead_q - 4'd1;
                        end else begin
                            active_d = pend_ratio_q;
                            dir_d    = pend_dir_q;
                            armed_d  = 1'b1;
                            consume  = 1'b1;
                            state_d  = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        // The load above used the buffer as it was before this cycle's write;
        // a same-cycle write therefore survives and re-validates the buffer.
        pend_ratio_d = pend_ratio_q;
        pend_dir_d   = pend_dir_q;
        pend_valid_d = pend_valid_q;
        if (pwm_update) begin
            pend_ratio_d = pwm_ratio;
            pend_dir_d   = pwm_direction;
            pend_valid_d = 1'b1;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            pre_q        <= 8'd0;
            cnt_q        <= 8'd0;
            active_q     <= 8'd0;
            pend_ratio_q <= 8'd0;
            pend_dir_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            dead_q       <= 4'd0;
            dir_q        <= 1'b0;
            pwm_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_ratio_q <= pend_ratio_d;
            pend_dir_q   <= pend_dir_d;
            pend_valid_q <= pend_valid_d;
            armed_q      <= armed_d;
            dead_q       <= dead_d;
            dir_q        <= dir_d;
            pwm_q        <= pwm_d;
            done_q       <= done_d;
        end
    end

    assign pwm_signal  = pwm_q;
    assign dir_signal  = dir_q;
    assign pwm_done    = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator
//   Checks pwm_generator at PRESCALE=4, DEAD_PERIODS=2 (period = 1020
//   clocks). Each test pushes one record per upcoming period boundary:
//   {dir, done, high_clocks}. A monitor counts pwm_signal high clocks over
//   each period and, at each boundary, pops and compares the record.
module tb_pwm_generator;

    localparam int PRE   = 4;
    localparam int DEADP = 2;
    localparam int L     = 255 * PRE;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pwm_enable = 1'b1;
    logic       pwm_update = 1'b0;
    logic [7:0] pwm_ratio = 8'd0;
    logic       pwm_direction = 1'b0;
    logic       pwm_done;
    logic       pwm_signal;
    logic       dir_signal;
    logic [1:0] dbg_state;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int stray_cnt = 0;
    int n         = 0;
    int acc       = 0;
    logic en_prev = 1'b1;
    logic [17:0] exp_q[$];

    pwm_generator #(
        .PRESCALE     (PRE),
        .DEAD_PERIODS (DEADP)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pwm_enable    (pwm_enable),
        .pwm_update    (pwm_update),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .pwm_done      (pwm_done),
        .pwm_signal    (pwm_signal),
        .dir_signal    (dir_signal),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // n = clocks since the period counter last restarted from 0
    always @(posedge clock) begin
        if (!reset_n || !pwm_enable || !en_prev) n <= 0;
        else                                     n <= n + 1;
        en_prev <= pwm_enable;
    end

    // The sample after edge n shows cycle n-1; edge k*L closes a period.
    always @(negedge clock) begin : mon
        int a;
        logic [17:0] rec;
        a = (n == 0) ? 0 : acc + int'(pwm_signal);
        if (n != 0 && (n % L) == 0) begin
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                check_val("period_high", a, {16'd0, rec[15:0]});
                check_val("period_done", {31'd0, pwm_done}, {31'd0, rec[16]});
                check_val("period_dir", {31'd0, dir_signal}, {31'd0, rec[17]});
            end else if (pwm_done) begin
                stray_cnt <= stray_cnt + 1;
            end
            acc <= 0;
        end else begin
            if (pwm_done) stray_cnt <= stray_cnt + 1;
            acc <= a;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_rec(input int high, input logic done, input logic dir);
        exp_q.push_back({dir, done, 16'(high)});
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (((n % L) != ph || n == 0) && guard < 3 * L);
        if ((n % L) != ph || n == 0) check_val("wait_phase_timeout", 1, 0);
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 12 * L) begin
            @(negedge clock);
            guard++;
        end
        check_val("queue_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_update(input logic [7:0] r, input logic d);
        pwm_ratio     = r;
        pwm_direction = d;
        pwm_update    = 1'b1;
        @(negedge clock);
        pwm_update    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi;
        int r;
        int prev_high;

        // reset state
        repeat (3) @(negedge clock);
        check_val("rst_sig", {31'd0, pwm_signal}, 0);
        check_val("rst_dir", {31'd0, dir_signal}, 0);
        check_val("rst_done", {31'd0, pwm_done}, 0);
        reset_n = 1'b1;

        // duty cycle: ratio 100 loads at first boundary, 400 highs next period
        wait_phase(500);
        pulse_update(8'd100, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        push_rec(100 * PRE, 1'b1, 1'b0);
        wait_empty();

        // ratio 0: no highs over 3 periods, one done
        wait_phase(500);
        pulse_update(8'd0, 1'b0);
        push_rec(100 * PRE, 1'b0, 1'b0);
        push_rec(0, 1'b1, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        wait_empty();

        // ratio 255: high the whole period
        wait_phase(500);
        pulse_update(8'd255, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        push_rec(L, 1'b1, 1'b0);
        push_rec(L, 1'b0, 1'b0);
        wait_empty();

        // direction reversal at ratio 150
        wait_phase(500);
        pulse_update(8'd150, 1'b0);
        push_rec(L, 1'b0, 1'b0);
        push_rec(150 * PRE, 1'b1, 1'b0);
        wait_empty();
        wait_phase(500);
        pulse_update(8'd150, 1'b1);
        push_rec(150 * PRE, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b1);
        push_rec(150 * PRE, 1'b1, 1'b1);
        wait_empty();

        // update exactly on the period_end cycle
        wait_phase(L - 1);
        push_rec(150 * PRE, 1'b0, 1'b1);
        push_rec(150 * PRE, 1'b0, 1'b1);
        push_rec(50 * PRE, 1'b1, 1'b1);
        pwm_ratio     = 8'd50;
        pwm_direction = 1'b1;
        pwm_update    = 1'b1;
        @(negedge clock);
        pwm_update    = 1'b0;
        wait_empty();

        // enable drop mid-high with a loaded, armed setting
        wait_phase(500);
        pulse_update(8'd60, 1'b1);
        push_rec(50 * PRE, 1'b0, 1'b1);
        wait_empty();
        wait_phase(100);
        check_val("en_pre_high", {31'd0, pwm_signal}, 1);
        pwm_enable = 1'b0;
        @(negedge clock);
        check_val("en_off_sig", {31'd0, pwm_signal}, 0);
        check_val("en_off_done", {31'd0, pwm_done}, 0);
        hi = 0;
        repeat (20) begin
            @(negedge clock);
            hi += int'(pwm_signal) + int'(pwm_done);
        end
        check_val("dis_activity", hi, 0);
        pwm_enable = 1'b1;
        push_rec(0, 1'b0, 1'b1);
        wait_empty();

        // re-enable with a setting written while disabled
        pwm_enable = 1'b0;
        @(negedge clock);
        pulse_update(8'd60, 1'b1);
        pwm_enable = 1'b1;
        push_rec(60 * PRE, 1'b1, 1'b1);
        wait_empty();

        // asynchronous reset mid-high with a pending setting
        wait_phase(50);
        pulse_update(8'd200, 1'b1);
        repeat (49) @(negedge clock);
        check_val("rst_pre_high", {31'd0, pwm_signal}, 1);
        #1 reset_n = 1'b0;
        #1;
        check_val("arst_sig", {31'd0, pwm_signal}, 0);
        check_val("arst_dir", {31'd0, dir_signal}, 0);
        check_val("arst_done", {31'd0, pwm_done}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        push_rec(0, 1'b0, 1'b0);
        push_rec(0, 1'b0, 1'b0);
        wait_empty();

        // upstream handshake: update held high, new ratio each period
        wait_phase(500);
        pwm_direction = 1'b0;
        pwm_update    = 1'b1;
        prev_high     = 0;
        for (int i = 0; i < 6; i++) begin
            r = int'($urandom_range(1, 254));
            pwm_ratio = r[7:0];
            push_rec(prev_high, (i > 0), 1'b0);
            prev_high = r * PRE;
            if (i < 5) wait_phase(500);
        end
        wait_empty();
        pwm_update = 1'b0;
        push_rec(prev_high, 1'b1, 1'b0);
        push_rec(prev_high, 1'b1, 1'b0);
        push_rec(prev_high, 1'b0, 1'b0);
        wait_empty();

        check_val("stray_done", stray_cnt, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
